// File: rtl/timer_display_scan_pkg.sv
// Shared types and constants for the timer display path: conversion FSM states,
// decade weights and active-low seven-segment patterns.
package timer_display_scan_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_D3,
    ST_D2,
    ST_D1,
    ST_COMMIT
  } conv_state_e;

  localparam logic [13:0] W_MIN   = 14'd600;
  localparam logic [13:0] W_SEC10 = 14'd100;
  localparam logic [13:0] W_SEC1  = 14'd10;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [7:0]  DP_MASK      = 8'h80;
  localparam logic [15:0] DIGITS_BLANK = 16'hFFFF;

  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/timer_display_scan_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder; blank shows a dash.
module seg7_decode
  import timer_display_scan_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = blank_i ? SEG_DASH : seg_pattern(digit_i);
  end

endmodule

// File: rtl/timer_display_scan.sv
// Converts the tenths-of-second timer count to M:SS.T digits by repeated subtraction
// and scans them onto a 4-digit common-anode seven-segment display.
module timer_display_scan
  import timer_display_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int MAX_COUNT = 5999
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [13:0] count_in,
  output logic [7:0]  seg_out,
  output logic [3:0]  dig_sel,
  output logic [15:0] digits_bcd,
  output logic        conv_done
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [13:0]      MAX_CNT  = 14'(MAX_COUNT);

  conv_state_e state_q, state_d;
  logic [13:0] rem_q, rem_d;
  logic [3:0]  min_q, min_d;
  logic [3:0]  sec10_q, sec10_d;
  logic [3:0]  sec1_q, sec1_d;
  logic        blank_pend_q, blank_pend_d;
  logic [15:0] digits_q, digits_d;
  logic        blank_q, blank_d;
  logic        conv_done_q, conv_done_d;

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       sel_q, sel_d;

  logic [13:0] weight;
  logic        rem_ge;
  logic [3:0]  scan_digit;
  logic [6:0]  seg_raw;

  always_comb begin
    case (state_q)
      ST_D2:   weight = W_SEC10;
      ST_D1:   weight = W_SEC1;
      default: weight = W_MIN;
    endcase
    rem_ge = (rem_q >= weight);
  end

  // Each digit state subtracts its weight until the remainder drops below it.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    min_d        = min_q;
    sec10_d      = sec10_q;
    sec1_d       = sec1_q;
    blank_pend_d = blank_pend_q;
    digits_d     = digits_q;
    blank_d      = blank_q;
    conv_done_d  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        rem_d        = count_in;
        min_d        = 4'd0;
        sec10_d      = 4'd0;
        sec1_d       = 4'd0;
        blank_pend_d = (count_in > MAX_CNT);
        state_d      = (count_in > MAX_CNT) ? ST_COMMIT : ST_D3;
      end
      ST_D3: begin
        if (rem_ge) begin
          rem_d = rem_q - weight;
          min_d = min_q + 4'd1;
        end else begin
          state_d = ST_D2;
        end
      end
      ST_D2: begin
        if (rem_ge) begin
          rem_d   = rem_q - weight;
          sec10_d = sec10_q + 4'd1;
        end else begin
          state_d = ST_D1;
        end
      end
      ST_D1: begin
        if (rem_ge) begin
          rem_d  = rem_q - weight;
          sec1_d = sec1_q + 4'd1;
        end else begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        conv_done_d = 1'b1;
        if (blank_pend_q) begin
          digits_d = DIGITS_BLANK;
          blank_d  = 1'b1;
        end else begin
          digits_d = {min_q, sec10_q, sec1_q, rem_q[3:0]};
          blank_d  = 1'b0;
        end
        state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end
    case (idx_q)
      2'd0:    scan_digit = digits_q[3:0];
      2'd1:    scan_digit = digits_q[7:4];
      2'd2:    scan_digit = digits_q[11:8];
      default: scan_digit = digits_q[15:12];
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit_i (scan_digit),
    .blank_i (blank_q),
    .seg_o   (seg_raw)
  );

  // Decimal points sit on the odd indices to read M.SS.T; dashes carry no point.
  always_comb begin
    seg_d = {1'b1, seg_raw};
    if (!blank_q && idx_q[0]) begin
      seg_d = seg_d & ~DP_MASK;
    end
    sel_d = ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      rem_q        <= '0;
      min_q        <= '0;
      sec10_q      <= '0;
      sec1_q       <= '0;
      blank_pend_q <= 1'b0;
      digits_q     <= '0;
      blank_q      <= 1'b0;
      conv_done_q  <= 1'b0;
      div_q        <= '0;
      idx_q        <= '0;
      seg_q        <= 8'hFF;
      sel_q        <= 4'hF;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      min_q        <= min_d;
      sec10_q      <= sec10_d;
      sec1_q       <= sec1_d;
      blank_pend_q <= blank_pend_d;
      digits_q     <= digits_d;
      blank_q      <= blank_d;
      conv_done_q  <= conv_done_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
    end
  end

  assign seg_out    = seg_q;
  assign dig_sel    = sel_q;
  assign digits_bcd = digits_q;
  assign conv_done  = conv_done_q;

endmodule

// File: tb/tb_timer_display_scan.sv
// Randomized scoreboard bench for timer_display_scan: a cycle-level model predicts
// each commit from the sampled count, and a monitor checks commits and the scan.
module tb_timer_display_scan;

  localparam int SCAN_DIV  = 4;
  localparam int MAX_COUNT = 5999;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic [13:0] count_in = '0;
  logic [7:0]  seg_out;
  logic [3:0]  dig_sel;
  logic [15:0] digits_bcd;
  logic        conv_done;

  timer_display_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .MAX_COUNT (MAX_COUNT)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .count_in   (count_in),
    .seg_out    (seg_out),
    .dig_sel    (dig_sel),
    .digits_bcd (digits_bcd),
    .conv_done  (conv_done)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [15:0] digits;
    int          due;
  } exp_t;

  exp_t        expQ[$];
  exp_t        pushItem;
  exp_t        popItem;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          nextLoad = 1;
  int          lastSample = 0;
  int          sampleVal;
  int          monIdx;
  logic        expDone;
  logic [3:0]  expSel;
  logic [15:0] modelDigits = '0;

  function automatic logic [15:0] expectDigits(input int c);
    if (c > MAX_COUNT) return 16'hFFFF;
    return {4'(c / 600), 4'((c % 600) / 100), 4'((c % 100) / 10), 4'(c % 10)};
  endfunction

  function automatic int convCycles(input int c);
    if (c > MAX_COUNT) return 2;
    return c / 600 + (c % 600) / 100 + (c % 100) / 10 + 5;
  endfunction

  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [7:0] expectSeg(input logic [15:0] d, input int idx);
    logic [3:0] nib;
    if (d == 16'hFFFF) return 8'hBF;
    nib = d[idx*4 +: 4];
    return {((idx % 2) == 0), segOf(nib)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [13:0] value, input int holdCycles);
    count_in = value;
    repeat (holdCycles) @(negedge clk_in);
  endtask

  task automatic resetChecks();
    checkOutput("rst_seg_out", seg_out, 8'hFF);
    checkOutput("rst_dig_sel", dig_sel, 4'hF);
    checkOutput("rst_digits_bcd", digits_bcd, 16'h0000);
    checkOutput("rst_conv_done", conv_done, 1'b0);
  endtask

  // Model: a conversion samples count_in at the closing edge of LOAD and takes a
  // count-dependent number of cycles; the next sample edge follows right after.
  always @(posedge clk_in) begin
    if (!rst_n) begin
      cyc        = 0;
      nextLoad   = 1;
      lastSample = 0;
      expQ.delete();
    end else begin
      cyc++;
      if (cyc == nextLoad) begin
        sampleVal       = int'(count_in);
        pushItem.digits = expectDigits(sampleVal);
        pushItem.due    = cyc + convCycles(sampleVal) - 1;
        expQ.push_back(pushItem);
        lastSample = cyc;
        nextLoad   = cyc + convCycles(sampleVal);
      end
    end
  end

  // Monitor: display reflects digits committed as of the previous edge.
  always @(negedge clk_in) begin
    if (!rst_n) begin
      modelDigits = '0;
    end else if (cyc > 0) begin
      monIdx = ((cyc - 1) / SCAN_DIV) % 4;
      expSel = ~(4'b0001 << monIdx);
      checkOutput("dig_sel", dig_sel, expSel);
      checkOutput("seg_out", seg_out, expectSeg(modelDigits, monIdx));
      expDone = (expQ.size() > 0) && (expQ[0].due == cyc);
      checkOutput("conv_done", conv_done, expDone);
      if (expDone) begin
        popItem = expQ.pop_front();
        modelDigits = popItem.digits;
        checkOutput("digits_bcd_commit", digits_bcd, popItem.digits);
      end else begin
        checkOutput("digits_bcd_hold", digits_bcd, modelDigits);
      end
    end
  end

  task automatic syncToLoad();
    logic found;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk_in);
      if (lastSample == cyc) found = 1'b1;
    end
    checkOutput("load_sync_timeout", found, 1'b1);
  endtask

  task automatic randomBurst(input int n);
    int r;
    int v;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      v = int'($urandom_range(6000, 16383));
      else if (r == 1) v = int'($urandom_range(5990, 5999));
      else             v = int'($urandom_range(0, 5999));
      applyStimulus(14'(v), int'($urandom_range(1, 35)));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1 resetChecks();
    @(negedge clk_in);
    #2 rst_n = 1'b1;
    @(negedge clk_in);

    applyStimulus(14'd5999, 40);
    applyStimulus(14'd1234, 30);
    applyStimulus(14'd6000, 20);
    applyStimulus(14'd0, 20);

    count_in = 14'd5999;
    syncToLoad();
    count_in = 14'd0;
    repeat (40) @(negedge clk_in);

    randomBurst(60);

    applyStimulus(14'd5999, 7);
    @(posedge clk_in);
    #3 rst_n = 1'b0;
    #1 resetChecks();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    #2 rst_n = 1'b1;
    @(negedge clk_in);
    applyStimulus(14'd1234, 40);

    randomBurst(30);
    repeat (5) @(negedge clk_in);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
